// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared constants and types for the CP0 exception sequencer.
// Cause codes, vector address, status bit positions, FSM states.
package cpu_defs_pkg;

    localparam logic [31:0] EXC_VECTOR    = 32'h00400004;
    localparam logic [3:0]  CAUSE_SYSCALL = 4'd8;
    localparam logic [3:0]  CAUSE_BREAK   = 4'd9;
    localparam logic [3:0]  CAUSE_TEQ     = 4'd13;

    localparam int ST_IE       = 0;
    localparam int ST_SYS_MASK = 1;
    localparam int ST_BRK_MASK = 2;
    localparam int ST_TEQ_MASK = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAVE,
        S_REDIR_EXC,
        S_RESTORE,
        S_REDIR_ERET
    } exc_state_t;

    typedef struct packed {
        logic       valid;
        logic       is_eret;
        logic [3:0] cause;
    } prio_t;

endpackage

// File: rtl/cp0_exc_ctrl_if.sv
// Core/CP0 side signal bundle of the exception sequencer.
// master = core/decode side, slave = the sequencer.
interface cp0_exc_ctrl_if;

    logic        req_syscall;
    logic        req_break;
    logic        req_teq;
    logic        req_eret;
    logic        mtc0_busy;
    logic [31:0] status;
    logic [31:0] epc;
    logic        exception;
    logic        eret;
    logic [3:0]  cause;
    logic        stall;
    logic        pc_load;
    logic [31:0] pc_target;
    logic        exc_active;

    modport master (
        output req_syscall, req_break, req_teq, req_eret,
        output mtc0_busy, status, epc,
        input  exception, eret, cause, stall,
        input  pc_load, pc_target, exc_active
    );

    modport slave (
        input  req_syscall, req_break, req_teq, req_eret,
        input  mtc0_busy, status, epc,
        output exception, eret, cause, stall,
        output pc_load, pc_target, exc_active
    );

endinterface

// File: rtl/cp0_exc_ctrl_prio_enc.sv
// Masked trap priority encoder: eret > syscall > break > teq.
// eret is never masked; traps need IE plus their own mask bit.
module exc_prio_enc
    import cpu_defs_pkg::*;
(
    input  logic       i_req_syscall,
    input  logic       i_req_break,
    input  logic       i_req_teq,
    input  logic       i_req_eret,
    input  logic [3:0] i_status,
    output prio_t      o_prio
);

    logic       w_sys;
    logic       w_brk;
    logic       w_teq;
    logic [3:0] w_sel;

    assign w_sys = i_req_syscall & i_status[ST_IE]
                 & i_status[ST_SYS_MASK];
    assign w_brk = i_req_break & i_status[ST_IE]
                 & i_status[ST_BRK_MASK];
    assign w_teq = i_req_teq & i_status[ST_IE]
                 & i_status[ST_TEQ_MASK];

    // one-hot winner, so the decoder below is truly unique
    assign w_sel[3] = i_req_eret;
    assign w_sel[2] = w_sys & ~i_req_eret;
    assign w_sel[1] = w_brk & ~w_sys & ~i_req_eret;
    assign w_sel[0] = w_teq & ~w_brk & ~w_sys & ~i_req_eret;

    // decode the winner into {valid, is_eret, cause}
    always_comb begin
        o_prio = '0;
        unique case (1'b1)
            w_sel[3]: begin
                o_prio.valid   = 1'b1;
                o_prio.is_eret = 1'b1;
            end
            w_sel[2]: begin
                o_prio.valid = 1'b1;
                o_prio.cause = CAUSE_SYSCALL;
            end
            w_sel[1]: begin
                o_prio.valid = 1'b1;
                o_prio.cause = CAUSE_BREAK;
            end
            w_sel[0]: begin
                o_prio.valid = 1'b1;
                o_prio.cause = CAUSE_TEQ;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception sequencer: IDLE -> SAVE/RESTORE -> REDIRECT -> IDLE.
// Stalls the core during the sequence and issues a one-cycle PC load.
module cp0_exc_ctrl
    import cpu_defs_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    cp0_exc_ctrl_if.slave bus
);

    prio_t       w_prio;
    logic        w_idle_stall;
    logic        w_go;
    logic        w_unused;
    exc_state_t  r_state;
    logic        r_exception;
    logic        r_eret;
    logic [3:0]  r_cause;
    logic        r_stall;
    logic        r_pc_load;
    logic [31:0] r_pc_target;
    logic        r_exc_active;

    assign w_unused = ^bus.status[31:4];

    exc_prio_enc u_prio (
        .i_req_syscall (bus.req_syscall),
        .i_req_break   (bus.req_break),
        .i_req_teq     (bus.req_teq),
        .i_req_eret    (bus.req_eret),
        .i_status      (bus.status[3:0]),
        .o_prio        (w_prio)
    );

    // an eligible request in IDLE stalls at once, even while mtc0 waits
    assign w_idle_stall = (r_state == S_IDLE) & w_prio.valid & ~rst;
    assign w_go         = w_idle_stall & ~bus.mtc0_busy;

    // sequencer FSM with registered CP0/PC outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_exception  <= 1'b0;
            r_eret       <= 1'b0;
            r_cause      <= '0;
            r_stall      <= 1'b0;
            r_pc_load    <= 1'b0;
            r_pc_target  <= '0;
            r_exc_active <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_stall      <= 1'b1;
                        r_exc_active <= 1'b1;
                        if (w_prio.is_eret) begin
                            r_state <= S_RESTORE;
                            r_eret  <= 1'b1;
                        end else begin
                            r_state     <= S_SAVE;
                            r_exception <= 1'b1;
                            r_cause     <= w_prio.cause;
                        end
                    end
                end
                S_SAVE: begin
                    r_state     <= S_REDIR_EXC;
                    r_exception <= 1'b0;
                    r_pc_load   <= 1'b1;
                    r_pc_target <= EXC_VECTOR;
                end
                S_RESTORE: begin
                    r_state     <= S_REDIR_ERET;
                    r_eret      <= 1'b0;
                    r_pc_load   <= 1'b1;
                    r_pc_target <= bus.epc;
                end
                S_REDIR_EXC, S_REDIR_ERET: begin
                    r_state      <= S_IDLE;
                    r_pc_load    <= 1'b0;
                    r_stall      <= 1'b0;
                    r_exc_active <= 1'b0;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_exception  <= 1'b0;
                    r_eret       <= 1'b0;
                    r_stall      <= 1'b0;
                    r_pc_load    <= 1'b0;
                    r_exc_active <= 1'b0;
                end
            endcase
        end
    end

    assign bus.exception  = r_exception;
    assign bus.eret       = r_eret;
    assign bus.cause      = r_cause;
    assign bus.stall      = r_stall | w_idle_stall;
    assign bus.pc_load    = r_pc_load;
    assign bus.pc_target  = r_pc_target;
    assign bus.exc_active = r_exc_active;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: cycle trace table plus
// a hand-written teq latency sequence and output invariants.
module tb_cp0_exc_ctrl;

    localparam logic [31:0] VEC = 32'h00400004;
    localparam logic [31:0] SF  = 32'h0000000F;

    typedef struct {
        logic        rst, sys, brk, teq, ert, busy;
        logic [31:0] st, epc;
        logic        x_exc, x_ert;
        logic [3:0]  x_cause;
        logic        x_stall, x_pl;
        logic [31:0] x_pt;
        logic        ck_pt, ck_act, x_act;
    } vec_t;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    int   lat;
    vec_t tv[$];

    cp0_exc_ctrl_if bus ();

    cp0_exc_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic rs, sy, bk, tq, er, bz,
        input logic [31:0] st, ep,
        input logic xe, xr,
        input logic [3:0] xc,
        input logic xs, xp,
        input logic [31:0] xt,
        input logic cp, ca, xa
    );
        vec_t v;
        v.rst = rs; v.sys = sy; v.brk = bk; v.teq = tq;
        v.ert = er; v.busy = bz; v.st = st; v.epc = ep;
        v.x_exc = xe; v.x_ert = xr; v.x_cause = xc;
        v.x_stall = xs; v.x_pl = xp; v.x_pt = xt;
        v.ck_pt = cp; v.ck_act = ca; v.x_act = xa;
        return v;
    endfunction

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        rst             = t.rst;
        bus.req_syscall = t.sys;
        bus.req_break   = t.brk;
        bus.req_teq     = t.teq;
        bus.req_eret    = t.ert;
        bus.mtc0_busy   = t.busy;
        bus.status      = t.st;
        bus.epc         = t.epc;
    endtask

    // exception/eret exclusive; no PC load while CP0 is being written
    always @(negedge clk) begin
        n_chk++;
        if ((bus.exception & bus.eret) === 1'b1 ||
            (bus.pc_load & (bus.exception | bus.eret)) === 1'b1) begin
            n_fail++;
            $display("FAIL invariant: exc=%b eret=%b pc_load=%b",
                     bus.exception, bus.eret, bus.pc_load);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        lat    = 0;
        drive(mk(1,0,0,0,0,0,SF,0, 0,0,0,0,0,0,0,0,0));

        // rst sy bk tq er bz status epc | exc ert cause stall pl pt ckpt ckact act
        tv.push_back(mk(1,0,0,0,0,0,SF,0, 0,0,0,0,0,0,1,1,0));
        tv.push_back(mk(0,0,0,0,0,0,SF,0, 0,0,0,0,0,0,1,1,0));
        // syscall, all enabled
        tv.push_back(mk(0,1,0,0,0,0,SF,0, 0,0,0,1,0,0,1,1,0));
        tv.push_back(mk(0,0,0,0,0,0,SF,0, 1,0,8,1,0,0,0,1,1));
        tv.push_back(mk(0,0,0,0,0,0,SF,0, 0,0,8,1,1,VEC,1,1,1));
        tv.push_back(mk(0,0,0,0,0,0,SF,0, 0,0,8,0,0,0,0,1,0));
        // break + teq together: break wins
        tv.push_back(mk(0,0,1,1,0,0,SF,0, 0,0,8,1,0,0,0,1,0));
        tv.push_back(mk(0,0,0,0,0,0,SF,0, 1,0,9,1,0,0,0,1,1));
        tv.push_back(mk(0,0,0,0,0,0,SF,0, 0,0,9,1,1,VEC,1,1,1));
        tv.push_back(mk(0,0,0,0,0,0,SF,0, 0,0,9,0,0,0,0,1,0));
        // teq masked, syscall with IE=0
        tv.push_back(mk(0,0,0,1,0,0,32'h7,0, 0,0,9,0,0,0,0,1,0));
        tv.push_back(mk(0,1,0,0,0,0,32'hE,0, 0,0,9,0,0,0,0,1,0));
        // eret; epc changes during redirect, sampled value holds
        tv.push_back(mk(0,0,0,0,1,0,SF,32'h00400120,
                        0,0,9,1,0,0,0,1,0));
        tv.push_back(mk(0,0,0,0,0,0,SF,32'h00400120,
                        0,1,9,1,0,0,0,0,0));
        tv.push_back(mk(0,0,0,0,0,0,SF,32'hDEAD0000,
                        0,0,9,1,1,32'h00400120,1,0,0));
        tv.push_back(mk(0,0,0,0,0,0,SF,0, 0,0,9,0,0,0,0,1,0));
        // syscall held off by mtc0 for 2 cycles
        tv.push_back(mk(0,1,0,0,0,1,SF,0, 0,0,9,1,0,0,0,1,0));
        tv.push_back(mk(0,1,0,0,0,1,SF,0, 0,0,9,1,0,0,0,1,0));
        tv.push_back(mk(0,1,0,0,0,0,SF,0, 0,0,9,1,0,0,0,1,0));
        tv.push_back(mk(0,0,0,0,0,0,SF,0, 1,0,8,1,0,0,0,1,1));
        tv.push_back(mk(0,0,0,0,0,0,SF,0, 0,0,8,1,1,VEC,1,1,1));
        tv.push_back(mk(0,0,0,0,0,0,SF,0, 0,0,8,0,0,0,0,1,0));
        // reset during SAVE aborts, no redirect
        tv.push_back(mk(0,0,1,0,0,0,SF,0, 0,0,8,1,0,0,0,1,0));
        tv.push_back(mk(1,0,0,0,0,0,SF,0, 1,0,9,1,0,0,0,1,1));
        tv.push_back(mk(0,0,0,0,0,0,SF,0, 0,0,0,0,0,0,1,1,0));
        tv.push_back(mk(0,0,0,0,0,0,SF,0, 0,0,0,0,0,0,1,1,0));
        // eret beats syscall
        tv.push_back(mk(0,1,0,0,1,0,SF,32'h00400200,
                        0,0,0,1,0,0,0,1,0));
        tv.push_back(mk(0,0,0,0,0,0,SF,32'h00400200,
                        0,1,0,1,0,0,0,0,0));
        tv.push_back(mk(0,0,0,0,0,0,SF,32'h00400200,
                        0,0,0,1,1,32'h00400200,1,0,0));
        tv.push_back(mk(0,0,0,0,0,0,SF,0, 0,0,0,0,0,0,0,1,0));
        // masked teq while mtc0 busy: no stall
        tv.push_back(mk(0,0,0,1,0,1,32'h7,0, 0,0,0,0,0,0,0,1,0));

        repeat (2) @(posedge clk);

        for (int i = 0; i < tv.size(); i++) begin
            @(posedge clk);
            #1;
            drive(tv[i]);
            @(negedge clk);
            chk($sformatf("r%0d exception", i),
                {31'd0, bus.exception}, {31'd0, tv[i].x_exc});
            chk($sformatf("r%0d eret", i),
                {31'd0, bus.eret}, {31'd0, tv[i].x_ert});
            chk($sformatf("r%0d cause", i),
                {28'd0, bus.cause}, {28'd0, tv[i].x_cause});
            chk($sformatf("r%0d stall", i),
                {31'd0, bus.stall}, {31'd0, tv[i].x_stall});
            chk($sformatf("r%0d pc_load", i),
                {31'd0, bus.pc_load}, {31'd0, tv[i].x_pl});
            if (tv[i].ck_pt)
                chk($sformatf("r%0d pc_target", i),
                    bus.pc_target, tv[i].x_pt);
            if (tv[i].ck_act)
                chk($sformatf("r%0d exc_active", i),
                    {31'd0, bus.exc_active}, {31'd0, tv[i].x_act});
        end

        // teq alone: request to pc_load must be exactly 2 cycles
        @(posedge clk);
        #1;
        drive(mk(0,0,0,1,0,0,SF,0, 0,0,0,0,0,0,0,0,0));
        @(negedge clk);
        chk("teq req stall", {31'd0, bus.stall}, 32'd1);
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            drive(mk(0,0,0,0,0,0,SF,0, 0,0,0,0,0,0,0,0,0));
            @(negedge clk);
            if (bus.pc_load === 1'b1) begin
                lat = c;
                break;
            end
        end
        chk("teq latency", lat, 32'd2);
        chk("teq cause", {28'd0, bus.cause}, 32'd13);
        chk("teq target", bus.pc_target, VEC);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("teq idle stall", {31'd0, bus.stall}, 32'd0);
        chk("teq idle pc_load", {31'd0, bus.pc_load}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
Exception sequencer that sits between the decode/control unit and the CP0 register file of the 54-instruction multi-cycle MIPS CPU. It arbitrates the trap sources (syscall, break, teq), gates them with the CP0 status mask, and drives the exception, eret and cause inputs of CP0 in a fixed multi-cycle sequence. While the sequence runs it stalls the core, then issues a one-cycle PC redirect to the exception vector or to the saved EPC.

Parameters:
EXC_VECTOR, 32'h00400004, exception entry address loaded on an exception redirect.
CAUSE_SYSCALL, 4'd8, cause code for syscall.
CAUSE_BREAK, 4'd9, cause code for break.
CAUSE_TEQ, 4'd13, cause code for a taken teq trap.

Ports:
clk  in  1  system clock; all state updates on posedge.
rst  in  1  synchronous, active-high reset.
req_syscall  in  1  decoded syscall instruction in the execute step.
req_break  in  1  decoded break instruction.
req_teq  in  1  teq with rs==rt (trap condition already true).
req_eret  in  1  decoded eret instruction.
mtc0_busy  in  1  mtc0 is writing CP0 in this cycle.
status  in  32  CP0 status register (cp0[12]).
epc  in  32  CP0 EPC (cp0[14]).
exception  out  1  to CP0: save status/cause/pc.
eret  out  1  to CP0: restore status.
cause  out  4  to CP0 cause field.
stall  out  1  freezes PC and IR while the sequence is active.
pc_load  out  1  one-cycle PC overwrite strobe.
pc_target  out  32  PC value written when pc_load=1.
exc_active  out  1  high from SAVE through REDIRECT; for debug and bench use.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; all outputs 0; cause=0; pc_target=0. Reset in any state aborts the sequence immediately.
- Enable rule: a source is eligible only when status[0] (IE) is 1 and its mask bit is 1.
  - syscall uses status[1].
  - break uses status[2].
  - teq uses status[3].
  - eret is never masked.
- Priority among simultaneous requests: eret > syscall > break > teq. Lower-priority requests in the same cycle are dropped; the core re-executes nothing.
- States and transitions:
  - IDLE: if an eligible trap is present and mtc0_busy=0, latch its cause code, go to SAVE, and assert stall combinationally in the same cycle. If eret is present and mtc0_busy=0, go to RESTORE with stall asserted. If mtc0_busy=1, stay in IDLE with stall=1 and re-evaluate next cycle, because CP0 gives mtc0 priority.
  - SAVE (1 cycle): exception=1, cause=latched code, stall=1. CP0 captures on the following negedge. Then go to REDIRECT_EXC.
  - REDIRECT_EXC (1 cycle): pc_load=1, pc_target=EXC_VECTOR, stall=1. Then go to IDLE.
  - RESTORE (1 cycle): eret=1, stall=1. Then go to REDIRECT_ERET.
  - REDIRECT_ERET (1 cycle): pc_load=1, pc_target=epc sampled at entry to this state, stall=1. Then go to IDLE.
- Latency: request to pc_load is 2 cycles, exactly.
- exception and eret are never high together. pc_load is never high in SAVE or RESTORE.
- cause holds its latched value outside SAVE; this is don't-care for CP0 but must be stable.
- Requests arriving while state≠IDLE are ignored; the core is stalled, so they reappear afterwards.
- Masked requests: the block produces no output at all. stall=0 and the instruction retires as a nop.
- A mtc0 to status in the cycle before a trap changes eligibility; status is sampled in IDLE only.

Decomposition:
- Shared package `cpu_defs_pkg`:
  - cause code constants.
  - EXC_VECTOR.
  - status bit indices (IE=0, SYS_MASK=1, BRK_MASK=2, TEQ_MASK=3).
  - state enum {IDLE, SAVE, REDIRECT_EXC, RESTORE, REDIRECT_ERET}.
- One sub-module, `exc_prio_enc`: combinational masked priority encoder producing {valid, is_eret, cause}. The FSM is instantiated in cp0_exc_ctrl.

Test Plan:
- Syscall with status=32'h0000000F → SAVE with exception=1 and cause=8; next cycle pc_load=1 with pc_target=32'h00400004; stall high for 3 cycles total; then IDLE.
- Break and teq together with status=32'h0000000F → cause=9 only. Then teq alone with status=32'h00000007 (teq masked) → no exception and stall=0.
- Syscall with status=32'h0000000E (IE=0) → all outputs stay 0.
- eret with epc=32'h00400120 → RESTORE with eret=1; next cycle pc_load=1 with pc_target=32'h00400120; exception stays 0 throughout.
- Syscall with mtc0_busy=1 for 2 cycles → stall=1 while waiting, no exception; SAVE begins the cycle after mtc0_busy falls.
- rst asserted during SAVE → next cycle all outputs 0, state IDLE, and no pc_load is issued.
